// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - single-outstanding fetch/data arbiter for the shared CPU memory bus
// Optional CPU_BUS_ARBITER_ROUND_ROBIN_EN: ties alternate against last grant; otherwise dbus wins ties.
module cpu_bus_arbiter (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_ibus_request,
    input  logic [31:0] i_ibus_address,
    output logic        o_ibus_ready,
    output logic [31:0] o_ibus_rdata,
    input  logic        i_dbus_request,
    input  logic        i_dbus_rw,
    input  logic [31:0] i_dbus_address,
    input  logic [31:0] i_dbus_wdata,
    output logic        o_dbus_ready,
    output logic [31:0] o_dbus_rdata,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant_d;
    logic        last_grant_d_next;
    logic        pick_d;
    logic        bus_request_next;
    logic        bus_rw_next;
    logic [31:0] bus_address_next;
    logic [31:0] bus_wdata_next;
    logic        ibus_ready_next;
    logic        dbus_ready_next;
    logic [31:0] ibus_rdata_next;
    logic [31:0] dbus_rdata_next;

    always_comb begin
        pick_d = i_dbus_request;
        if (i_ibus_request && i_dbus_request) begin
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
            pick_d = !last_grant_d;
`else
            pick_d = 1'b1;
`endif
        end
    end

    always_comb begin
        state_next        = state;
        last_grant_d_next = last_grant_d;
        bus_request_next  = o_bus_request;
        bus_rw_next       = o_bus_rw;
        bus_address_next  = o_bus_address;
        bus_wdata_next    = o_bus_wdata;
        ibus_ready_next   = 1'b0;
        dbus_ready_next   = 1'b0;
        ibus_rdata_next   = o_ibus_rdata;
        dbus_rdata_next   = o_dbus_rdata;
        case (state)
            IDLE: begin
                if (i_ibus_request || i_dbus_request) begin
                    bus_request_next = 1'b1;
                    if (pick_d) begin
                        bus_address_next = i_dbus_address;
                        bus_rw_next      = i_dbus_rw;
                        bus_wdata_next   = i_dbus_wdata;
                        state_next       = GNT_D;
                    end else begin
                        bus_address_next = i_ibus_address;
                        bus_rw_next      = 1'b0;
                        state_next       = GNT_I;
                    end
                end
            end
            GNT_I: begin
                if (i_bus_ready) begin
                    bus_request_next  = 1'b0;
                    ibus_ready_next   = 1'b1;
                    ibus_rdata_next   = i_bus_rdata;
                    last_grant_d_next = 1'b0;
                    state_next        = ACK;
                end
            end
            GNT_D: begin
                if (i_bus_ready) begin
                    bus_request_next  = 1'b0;
                    dbus_ready_next   = 1'b1;
                    if (!o_bus_rw) begin
                        dbus_rdata_next = i_bus_rdata;
                    end
                    last_grant_d_next = 1'b1;
                    state_next        = ACK;
                end
            end
            // Requests are ignored here: the served requester is still dropping its request.
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= IDLE;
            last_grant_d  <= 1'b0;
            o_bus_request <= 1'b0;
            o_bus_rw      <= 1'b0;
            o_bus_address <= 32'd0;
            o_bus_wdata   <= 32'd0;
            o_ibus_ready  <= 1'b0;
            o_dbus_ready  <= 1'b0;
            o_ibus_rdata  <= 32'd0;
            o_dbus_rdata  <= 32'd0;
        end else begin
            state         <= state_next;
            last_grant_d  <= last_grant_d_next;
            o_bus_request <= bus_request_next;
            o_bus_rw      <= bus_rw_next;
            o_bus_address <= bus_address_next;
            o_bus_wdata   <= bus_wdata_next;
            o_ibus_ready  <= ibus_ready_next;
            o_dbus_ready  <= dbus_ready_next;
            o_ibus_rdata  <= ibus_rdata_next;
            o_dbus_rdata  <= dbus_rdata_next;
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb/tb_cpu_bus_arbiter.sv - transaction-level self-checking bench for cpu_bus_arbiter
module tb_cpu_bus_arbiter;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_ibus_request;
    logic [31:0] i_ibus_address;
    logic        o_ibus_ready;
    logic [31:0] o_ibus_rdata;
    logic        i_dbus_request;
    logic        i_dbus_rw;
    logic [31:0] i_dbus_address;
    logic [31:0] i_dbus_wdata;
    logic        o_dbus_ready;
    logic [31:0] o_dbus_rdata;
    logic        o_bus_request;
    logic        o_bus_rw;
    logic [31:0] o_bus_address;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ready;
    logic [31:0] i_bus_rdata;
    logic        o_busy;

    cpu_bus_arbiter dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_ibus_request (i_ibus_request),
        .i_ibus_address (i_ibus_address),
        .o_ibus_ready   (o_ibus_ready),
        .o_ibus_rdata   (o_ibus_rdata),
        .i_dbus_request (i_dbus_request),
        .i_dbus_rw      (i_dbus_rw),
        .i_dbus_address (i_dbus_address),
        .i_dbus_wdata   (i_dbus_wdata),
        .o_dbus_ready   (o_dbus_ready),
        .o_dbus_rdata   (o_dbus_rdata),
        .o_bus_request  (o_bus_request),
        .o_bus_rw       (o_bus_rw),
        .o_bus_address  (o_bus_address),
        .o_bus_wdata    (o_bus_wdata),
        .i_bus_ready    (i_bus_ready),
        .i_bus_rdata    (i_bus_rdata),
        .o_busy         (o_busy)
    );

    always #5 i_clock = ~i_clock;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: pending requests per port plus the values each output should hold.
    bit          pend_i, pend_d, drw, last_d;
    logic [31:0] ia, da, dw;
    logic [31:0] m_irdata, m_drdata, m_bus_wdata;
    string       grant_log;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic drive_requests();
        i_ibus_request = pend_i;
        i_ibus_address = ia;
        i_dbus_request = pend_d;
        i_dbus_address = da;
        i_dbus_rw      = drw;
        i_dbus_wdata   = dw;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_bus_request"}, {31'd0, o_bus_request}, 32'd0);
        chk({tag, "_bus_rw"},      {31'd0, o_bus_rw},      32'd0);
        chk({tag, "_bus_address"}, o_bus_address,          32'd0);
        chk({tag, "_bus_wdata"},   o_bus_wdata,            32'd0);
        chk({tag, "_ibus_ready"},  {31'd0, o_ibus_ready},  32'd0);
        chk({tag, "_dbus_ready"},  {31'd0, o_dbus_ready},  32'd0);
        chk({tag, "_ibus_rdata"},  o_ibus_rdata,           32'd0);
        chk({tag, "_dbus_rdata"},  o_dbus_rdata,           32'd0);
        chk({tag, "_busy"},        {31'd0, o_busy},        32'd0);
    endtask

    // Called in an IDLE cycle; returns in the following IDLE cycle with the winner's request dropped.
    task automatic round(input bit ni, input logic [31:0] nia, input bit nd, input bit nrw,
                         input logic [31:0] nda, input logic [31:0] ndw, input int w,
                         input logic [31:0] rd);
        bit          win_d;
        logic [31:0] e_addr;
        logic        e_rw;
        if (ni && !pend_i) begin pend_i = 1; ia = nia; end
        if (nd && !pend_d) begin pend_d = 1; da = nda; dw = ndw; drw = nrw; end
        drive_requests();
        i_bus_ready = 1'($urandom_range(0, 1));
        i_bus_rdata = $urandom;
        if (!pend_i && !pend_d) begin
            tick();
            chk("idle_bus_request", {31'd0, o_bus_request}, 32'd0);
            chk("idle_busy",        {31'd0, o_busy},        32'd0);
        end else begin
            if (pend_i && pend_d) begin
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
                win_d = !last_d;
`else
                win_d = 1'b1;
`endif
            end else begin
                win_d = pend_d;
            end
            e_addr = win_d ? da : ia;
            e_rw   = win_d ? drw : 1'b0;
            if (win_d) m_bus_wdata = dw;
            grant_log = {grant_log, win_d ? "D" : "I"};
            tick();
            for (int c = 0; c <= w; c++) begin
                chk("gnt_bus_request", {31'd0, o_bus_request}, 32'd1);
                chk("gnt_bus_address", o_bus_address,          e_addr);
                chk("gnt_bus_rw",      {31'd0, o_bus_rw},      {31'd0, e_rw});
                chk("gnt_bus_wdata",   o_bus_wdata,            m_bus_wdata);
                chk("gnt_busy",        {31'd0, o_busy},        32'd1);
                chk("gnt_ready_pair",  {30'd0, o_ibus_ready, o_dbus_ready}, 32'd0);
                i_bus_ready = (c == w);
                i_bus_rdata = (c == w) ? rd : $urandom;
                tick();
            end
            if (!win_d) m_irdata = rd;
            else if (!drw) m_drdata = rd;
            last_d = win_d;
            chk("ack_bus_request", {31'd0, o_bus_request}, 32'd0);
            chk("ack_ibus_ready",  {31'd0, o_ibus_ready},  {31'd0, !win_d});
            chk("ack_dbus_ready",  {31'd0, o_dbus_ready},  {31'd0, win_d});
            chk("ack_ibus_rdata",  o_ibus_rdata,           m_irdata);
            chk("ack_dbus_rdata",  o_dbus_rdata,           m_drdata);
            chk("ack_busy",        {31'd0, o_busy},        32'd1);
            // Requester is still high during ACK; a stray ready here must not matter.
            i_bus_ready = 1'($urandom_range(0, 1));
            tick();
            chk("post_bus_request", {31'd0, o_bus_request}, 32'd0);
            chk("post_ready_pair",  {30'd0, o_ibus_ready, o_dbus_ready}, 32'd0);
            chk("post_busy",        {31'd0, o_busy},        32'd0);
            chk("post_ibus_rdata",  o_ibus_rdata,           m_irdata);
            chk("post_dbus_rdata",  o_dbus_rdata,           m_drdata);
            if (win_d) pend_d = 0; else pend_i = 0;
            drive_requests();
        end
    endtask

    task automatic model_reset();
        pend_i = 0; pend_d = 0; last_d = 0; drw = 0;
        m_irdata = 0; m_drdata = 0; m_bus_wdata = 0;
    endtask

    initial begin
        ia = 0; da = 0; dw = 0;
        model_reset();
        grant_log = "";
        i_reset = 1'b1;
        i_bus_ready = 1'b0;
        i_bus_rdata = 32'd0;
        drive_requests();
        tick();
        tick();
        check_all_zero("reset");
        i_reset = 1'b0;

        // Single fetch, W=2.
        round(1, 32'h0000_0100, 0, 0, 0, 0, 2, 32'h0000_0013);
        chk("fetch_grant", {31'd0, last_d}, 32'd0);
        // Data write, W=0: dbus rdata must stay unchanged.
        round(0, 0, 1, 1, 32'h0000_2000, 32'hDEAD_BEEF, 0, 32'h1234_5678);
        chk("write_rdata_hold", o_dbus_rdata, 32'd0);

        // Reset mid GNT_I with W=5, then a stray ready for the aborted transfer.
        pend_i = 1; ia = 32'h0000_0400;
        drive_requests();
        tick();
        chk("abort_gnt_request", {31'd0, o_bus_request}, 32'd1);
        tick();
        i_reset = 1'b1;
        tick();
        model_reset();
        drive_requests();
        i_reset = 1'b0;
        check_all_zero("abort");
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'hBAD0_BAD0;
        repeat (2) begin
            tick();
            chk("abort_late_request", {31'd0, o_bus_request}, 32'd0);
            chk("abort_late_iready",  {31'd0, o_ibus_ready},  32'd0);
            chk("abort_late_busy",    {31'd0, o_busy},        32'd0);
        end
        i_bus_ready = 1'b0;

        // Held simultaneous requests, then dbus stops and fetch drains.
        grant_log = "";
        for (int k = 0; k < 4; k++) begin
            round(1, 32'h0000_1000 + 32'(k * 4), 1, 1'(k & 1), 32'h0000_3000 + 32'(k * 8),
                  $urandom, k % 3, $urandom);
        end
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
        chk("tie_order", {grant_log == "DIDI"}, 32'd1);
`else
        chk("tie_order", {grant_log == "DDDD"}, 32'd1);
`endif
        round(0, 0, 0, 0, 0, 0, 0, 32'h0000_0000);
        round(0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
        round(0, 0, 0, 0, 0, 0, 0, 32'h0000_0000);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            round(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 3), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
